// File: rtl/irda_tx_arbiter.sv
// Round-robin arbiter sharing one IrDA byte transmitter between NREQ clients.
// Optional watchdog abort enabled by defining IRDA_ARB_TIMEOUT_EN.
module irda_tx_arbiter #(
   parameter int NREQ    = 4,
   parameter int DW      = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      ack,
   output logic                 tx_send,
   output logic [DW-1:0]        tx_data,
   input  logic                 tx_done,
   output logic                 busy,
   output logic                 timeout_err
);

   localparam int PW = $clog2(NREQ);

   if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("NREQ out of range");
   end
   if (TIMEOUT < 2) begin : g_bad_to
      $error("TIMEOUT too small");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_REL,
      S_ACK
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   k_q, k_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic            send_q, send_d;
   logic [DW-1:0]   data_q, data_d;
   logic            busy_q, busy_d;
   logic [PW-1:0]   win;
   logic [PW-1:0]   idx;

   // Lowest offset from ptr wins: later (smaller) offsets overwrite earlier ones.
   always_comb begin
      win = ptr_q;
      idx = ptr_q;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = PW'((int'(ptr_q) + i) % NREQ);
         if (req[idx]) win = idx;
      end
   end

`ifdef IRDA_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          terr_q, terr_d;
   logic          to_hit;

   assign to_hit = (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      cnt_d = '0;
      if (state_q == S_SEND || state_q == S_REL) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         terr_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         terr_q <= terr_d;
      end
   end

   assign timeout_err = terr_q;
`else
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      k_d     = k_q;
      gnt_d   = gnt_q;
      ack_d   = '0;
      send_d  = send_q;
      data_d  = data_q;
      busy_d  = busy_q;
`ifdef IRDA_ARB_TIMEOUT_EN
      terr_d  = 1'b0;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (|req) begin
               state_d = S_SEND;
               k_d     = win;
               gnt_d   = NREQ'(1) << win;
               data_d  = req_data[int'(win)*DW +: DW];
               send_d  = 1'b1;
               busy_d  = 1'b1;
            end
         end
         S_SEND: begin
            if (tx_done) begin
               state_d = S_REL;
               send_d  = 1'b0;
            end
`ifdef IRDA_ARB_TIMEOUT_EN
            else if (to_hit) begin
               state_d = S_ACK;
               send_d  = 1'b0;
               ack_d   = gnt_q;
               terr_d  = 1'b1;
            end
`endif
         end
         S_REL: begin
            if (!tx_done) begin
               state_d = S_ACK;
               ack_d   = gnt_q;
            end
`ifdef IRDA_ARB_TIMEOUT_EN
            else if (to_hit) begin
               state_d = S_ACK;
               ack_d   = gnt_q;
               terr_d  = 1'b1;
            end
`endif
         end
         S_ACK: begin
            state_d = S_IDLE;
            ptr_d   = PW'((int'(k_q) + 1) % NREQ);
            gnt_d   = '0;
            data_d  = '0;
            busy_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         k_q     <= '0;
         gnt_q   <= '0;
         ack_q   <= '0;
         send_q  <= 1'b0;
         data_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         k_q     <= k_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         send_q  <= send_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
      end
   end

   assign gnt     = gnt_q;
   assign ack     = ack_q;
   assign tx_send = send_q;
   assign tx_data = data_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_irda_tx_arbiter.sv
// Directed bench for irda_tx_arbiter with a simple transmitter model.
module tb_irda_tx_arbiter;

`ifdef IRDA_ARB_TIMEOUT_EN
   localparam int TB_TO = 64;
`else
   localparam int TB_TO = 4096;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  gnt;
   logic [3:0]  ack;
   logic        tx_send;
   logic [7:0]  tx_data;
   logic        tx_done = 1'b0;
   logic        busy;
   logic        timeout_err;

   int n_chk = 0;
   int n_fail = 0;

   bit model_en = 1'b1;
   int scnt = 0;
   int rcnt = 0;

   irda_tx_arbiter #(.NREQ(4), .DW(8), .TIMEOUT(TB_TO)) dut (
      .clk(clk),
      .reset(reset),
      .req(req),
      .req_data(req_data),
      .gnt(gnt),
      .ack(ack),
      .tx_send(tx_send),
      .tx_data(tx_data),
      .tx_done(tx_done),
      .busy(busy),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Transmitter: done 20 cycles after send rises, clears 2 cycles after send falls.
   always @(posedge clk) begin
      #2;
      if (model_en) begin
         if (tx_send) begin
            scnt++;
            rcnt = 0;
            if (scnt >= 20) tx_done = 1'b1;
         end else begin
            scnt = 0;
            if (tx_done) begin
               rcnt++;
               if (rcnt >= 2) begin
                  tx_done = 1'b0;
                  rcnt = 0;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_ack(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (ack != 4'b0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      n_chk++;
      if (gnt !== 4'b0) begin
         n_fail++;
         $display("FAIL rst_gnt got=%b exp=0000", gnt);
      end
      n_chk++;
      if (ack !== 4'b0) begin
         n_fail++;
         $display("FAIL rst_ack got=%b exp=0000", ack);
      end
      n_chk++;
      if (tx_send !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_ctl got=%b%b%b exp=000", tx_send, busy, timeout_err);
      end
      n_chk++;
      if (tx_data !== 8'h00) begin
         n_fail++;
         $display("FAIL rst_data got=%h exp=00", tx_data);
      end
      reset = 1'b0;
   endtask

   task automatic test_single();
      bit ok;
      req_data[7:0] = 8'hA5;
      req = 4'b0001;
      tick();
      n_chk++;
      if (gnt !== 4'b0001 || tx_data !== 8'hA5) begin
         n_fail++;
         $display("FAIL single_gnt got=%b/%h exp=0001/a5", gnt, tx_data);
      end
      n_chk++;
      if (tx_send !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_send got=%b%b exp=11", tx_send, busy);
      end
      wait_ack(ok);
      n_chk++;
      if (!ok || ack !== 4'b0001 || gnt !== 4'b0001 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_ack got=%b/%b/%b exp=0001/0001/1", ack, gnt, busy);
      end
      req = '0;
      tick();
      n_chk++;
      if (ack !== 4'b0 || busy !== 1'b0 || gnt !== 4'b0) begin
         n_fail++;
         $display("FAIL single_end got=%b/%b/%b exp=0000/0/0000", ack, busy, gnt);
      end
   endtask

   task automatic test_contention();
      int order[6] = '{0, 1, 3, 0, 1, 3};
      bit ok;
      bit two;
      do_reset();
      req_data = 32'h13121110;
      req = 4'b1011;
      for (int j = 0; j < 6; j++) begin
         ok = 1'b0;
         for (int i = 0; i < 10; i++) begin
            if (gnt != 4'b0) begin
               ok = 1'b1;
               break;
            end
            tick();
         end
         n_chk++;
         if (!ok || gnt !== (4'b0001 << order[j])) begin
            n_fail++;
            $display("FAIL cont_gnt%0d got=%b exp_port=%0d", j, gnt, order[j]);
         end
         n_chk++;
         if (tx_data !== 8'(8'h10 + order[j])) begin
            n_fail++;
            $display("FAIL cont_data%0d got=%h exp=%h", j, tx_data, 8'(8'h10 + order[j]));
         end
         two = 1'b0;
         ok = 1'b0;
         for (int i = 0; i < 100; i++) begin
            if (ack != 4'b0) begin
               ok = 1'b1;
               break;
            end
            if (!$onehot(gnt)) two = 1'b1;
            tick();
         end
         n_chk++;
         if (!ok || two || ack !== (4'b0001 << order[j])) begin
            n_fail++;
            $display("FAIL cont_ack%0d got=%b multi=%0b exp_port=%0d", j, ack, two, order[j]);
         end
         if (j == 5) req = '0;
         tick();
      end
   endtask

   task automatic test_withdraw();
      bit ok;
      req_data = 32'h005C003A;
      req = 4'b0100;
      tick();
      n_chk++;
      if (gnt !== 4'b0100) begin
         n_fail++;
         $display("FAIL wd_gnt got=%b exp=0100", gnt);
      end
      req = 4'b0101;
      tick();
      tick();
      tick();
      req = 4'b0001;
      wait_ack(ok);
      n_chk++;
      if (!ok || ack !== 4'b0100 || tx_data !== 8'h5C) begin
         n_fail++;
         $display("FAIL wd_ack got=%b/%h exp=0100/5c", ack, tx_data);
      end
      tick();
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (gnt != 4'b0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      n_chk++;
      if (!ok || gnt !== 4'b0001 || tx_data !== 8'h3A) begin
         n_fail++;
         $display("FAIL wd_next got=%b/%h exp=0001/3a", gnt, tx_data);
      end
      wait_ack(ok);
      req = '0;
      tick();
   endtask

   task automatic test_reset_mid();
      bit ok;
      req_data = 32'h44332211;
      req = 4'b1111;
      tick();
      n_chk++;
      if (gnt !== 4'b0010) begin
         n_fail++;
         $display("FAIL rm_first got=%b exp=0010", gnt);
      end
      tick();
      tick();
      tick();
      n_chk++;
      if (tx_send !== 1'b1) begin
         n_fail++;
         $display("FAIL rm_insend got=%b exp=1", tx_send);
      end
      reset = 1'b1;
      tick();
      n_chk++;
      if (tx_send !== 1'b0 || gnt !== 4'b0 || ack !== 4'b0) begin
         n_fail++;
         $display("FAIL rm_abort got=%b/%b/%b exp=0/0000/0000", tx_send, gnt, ack);
      end
      reset = 1'b0;
      tick();
      n_chk++;
      if (gnt !== 4'b0001 || tx_data !== 8'h11) begin
         n_fail++;
         $display("FAIL rm_regnt got=%b/%h exp=0001/11", gnt, tx_data);
      end
      wait_ack(ok);
      req = '0;
      tick();
   endtask

   task automatic test_timeout();
`ifdef IRDA_ARB_TIMEOUT_EN
      int n;
      model_en = 1'b0;
      tx_done = 1'b0;
      req_data[7:0] = 8'h77;
      req = 4'b0001;
      tick();
      n = 0;
      while (tx_send === 1'b1 && n < 200) begin
         n++;
         tick();
      end
      n_chk++;
      if (n != 64) begin
         n_fail++;
         $display("FAIL to_len got=%0d exp=64", n);
      end
      n_chk++;
      if (ack !== 4'b0001 || timeout_err !== 1'b1) begin
         n_fail++;
         $display("FAIL to_ack got=%b/%b exp=0001/1", ack, timeout_err);
      end
      req = '0;
      tick();
      n_chk++;
      if (ack !== 4'b0 || timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL to_pulse got=%b/%b exp=0000/0", ack, timeout_err);
      end
      model_en = 1'b1;
`else
      bit bad;
      model_en = 1'b0;
      tx_done = 1'b0;
      req = 4'b0001;
      tick();
      bad = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         if (tx_send !== 1'b1 || timeout_err !== 1'b0) bad = 1'b1;
         tick();
      end
      n_chk++;
      if (bad) begin
         n_fail++;
         $display("FAIL noto_hold got=%b/%b exp=1/0", tx_send, timeout_err);
      end
      do_reset();
      model_en = 1'b1;
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_withdraw();
      test_reset_mid();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
